phy_rx_lane_deser: RTL and testbench

Parametrised multi-lane PHY reception front end. It takes one serial bit per lane per clk_32f, finds symbol boundaries on the COM character and locks each lane independently. It aligns the lanes to each other to within one symbol, then stripes the data symbols into DATA_W-bit words with a one-cycle valid_out strobe. Sits between the lane serial inputs and the link-layer word interface; generalises the 2-lane, 32-bit receive path to N lanes.

---
 rtl/phy_rx_pkg.sv | 21 ++
 rtl/phy_rx_lane_align.sv | 78 +++++++
 rtl/phy_rx_lane_deser.sv | 99 +++++++++
 tb/tb_phy_rx_lane_deser.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared lane state encoding, default COM character and sizing helpers
package phy_rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lane_state_e;

    localparam logic [7:0] COM_DEFAULT = 8'hBC;
    localparam int DEF_LANES  = 2;
    localparam int DEF_SYM_W  = 8;
    localparam int DEF_DATA_W = 32;
    localparam int GROUPS     = DEF_DATA_W / (DEF_SYM_W * DEF_LANES);
    localparam int BIT_CNT_W  = $clog2(DEF_SYM_W);

    function automatic int width_of(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/phy_rx_lane_align.sv
// phy_rx_lane_align: per-lane COM boundary search, lock FSM and one-deep symbol hold register
module phy_rx_lane_align
    import phy_rx_pkg::*;
#(
    parameter int               SYM_W    = 8,
    parameter logic [SYM_W-1:0] COM      = COM_DEFAULT,
    parameter int               LOCK_CNT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bit_i,
    input  logic             consume_i,
    output logic [SYM_W-1:0] sym_o,
    output logic             sym_v_o,
    output logic             locked_o
);

    localparam int CW = width_of(SYM_W);
    localparam int LW = width_of(LOCK_CNT + 1);

    lane_state_e      state_q, state_d;
    logic [SYM_W-1:0] shift_q, shift_d, hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    com_q, com_d;
    logic             hold_v_q, hold_v_d;
    logic             sym_done, is_com;

    always_comb begin
        shift_d  = {shift_q[SYM_W-2:0], bit_i};
        sym_done = cnt_q == CW'(SYM_W - 1);
        cnt_d    = sym_done ? '0 : cnt_q + 1'b1;
        is_com   = shift_d == COM;
        state_d  = state_q;
        com_d    = com_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q & ~consume_i;
        case (state_q)
            HUNT: if (is_com) begin
                cnt_d   = '0;
                com_d   = LW'(1);
                state_d = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
            end
            ACQUIRE: if (sym_done) begin
                com_d   = is_com ? com_q + 1'b1 : '0;
                state_d = !is_com ? HUNT : (com_d == LW'(LOCK_CNT)) ? LOCKED : ACQUIRE;
            end
            LOCKED: if (sym_done) begin
                // a symbol still waiting for the slowest lane is simply overwritten
                hold_d   = shift_d;
                hold_v_d = 1'b1;
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= HUNT;
            shift_q  <= '0;
            cnt_q    <= '0;
            com_q    <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            com_q    <= com_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

    assign sym_o    = hold_q;
    assign sym_v_o  = hold_v_q;
    assign locked_o = state_q == LOCKED;

endmodule

// File: rtl/phy_rx_lane_deser.sv
// phy_rx_lane_deser: multi-lane serial receive front end, lane deskew and word striping
// Define PHY_RX_LOCK_STATUS_EN to add the lock_out/all_locked status outputs.
module phy_rx_lane_deser
    import phy_rx_pkg::*;
#(
    parameter int               LANES    = 2,
    parameter int               SYM_W    = 8,
    parameter int               DATA_W   = 32,
    parameter logic [SYM_W-1:0] COM      = COM_DEFAULT,
    parameter int               LOCK_CNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [LANES-1:0]  data_in,
    output logic [DATA_W-1:0] data_out,
`ifdef PHY_RX_LOCK_STATUS_EN
    output logic [LANES-1:0]  lock_out,
    output logic              all_locked,
`endif
    output logic              valid_out
);

    localparam int GW  = SYM_W * LANES;
    localparam int NG  = DATA_W / GW;
    localparam int GIW = width_of(NG);

    logic [LANES-1:0][SYM_W-1:0] sym;
    logic [LANES-1:0]            sym_v, locked, com_hit;
    logic                        consume;
    logic [GIW-1:0]              group_q, group_d;
    logic [DATA_W-1:0]           word_q, word_d, data_q, data_d;
    logic                        done_q, done_d, valid_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        phy_rx_lane_align #(
            .SYM_W    (SYM_W),
            .COM      (COM),
            .LOCK_CNT (LOCK_CNT)
        ) u_lane (
            .clk_i     (clk_32f),
            .rst_ni    (reset),
            .bit_i     (data_in[l]),
            .consume_i (consume),
            .sym_o     (sym[l]),
            .sym_v_o   (sym_v[l]),
            .locked_o  (locked[l])
        );
        assign com_hit[l] = sym[l] == COM;
    end

    assign consume = &locked & &sym_v;

    always_comb begin
        group_d = group_q;
        word_d  = word_q;
        done_d  = 1'b0;
        data_d  = done_q ? word_q : data_q;
        // a COM anywhere in the group realigns the word to start after it
        if (consume && |com_hit) begin
            group_d = '0;
        end else if (consume) begin
            word_d[group_q*GW +: GW] = sym;
            done_d  = group_q == GIW'(NG - 1);
            group_d = done_d ? '0 : group_q + 1'b1;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            group_q <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            group_q <= group_d;
            word_q  <= word_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= done_q;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

`ifdef PHY_RX_LOCK_STATUS_EN
    logic [LANES-1:0] lock_q;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) lock_q <= '0;
        else        lock_q <= locked;
    end

    assign lock_out   = lock_q;
    assign all_locked = &lock_q;
`endif

endmodule

// File: tb/tb_phy_rx_lane_deser.sv
// tb_phy_rx_lane_deser: directed vectors for the 2-lane, 32-bit receive path
module tb_phy_rx_lane_deser;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic [1:0]  data_in = '0;
    logic [31:0] data_out;
    logic        valid_out;
`ifdef PHY_RX_LOCK_STATUS_EN
    logic [1:0]  lock_out;
    logic        all_locked;
`endif

    int         n_cmp = 0, n_bad = 0;
    int         vcnt = 0, vtime = 0, ltime = 0, tstart = 0;
    logic [7:0] com_v = 8'hBC;

    phy_rx_lane_deser #(
        .LANES    (2),
        .SYM_W    (8),
        .DATA_W   (32),
        .COM      (8'hBC),
        .LOCK_CNT (4)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
`ifdef PHY_RX_LOCK_STATUS_EN
        .lock_out   (lock_out),
        .all_locked (all_locked),
`endif
        .valid_out  (valid_out)
    );

    always #5 clk_32f = ~clk_32f;

    always @(negedge clk_32f) begin
        if (valid_out) begin
            vcnt++;
            vtime = int'($time);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk_32f);
        reset = 1'b1;
    endtask

    // symbol 0 is the leftmost byte of s0/s1; lane 1 lags lane 0 by skew bits,
    // and once a lane runs out of symbols it idles with COM on its own grid
    task automatic play(input logic [127:0] s0, input logic [127:0] s1,
                        input int n, input int skew, input int dlast, input int nbits);
        int j;
        for (int k = 0; k < nbits; k++) begin
            j = k - skew;
            @(negedge clk_32f);
            if (k == 0) tstart = int'($time);
            data_in[0] = (k < n*8) ? s0[(n-1-k/8)*8 + 7 - k%8] : com_v[7 - k%8];
            data_in[1] = (j < 0) ? 1'b0 : (j < n*8) ? s1[(n-1-j/8)*8 + 7 - j%8] : com_v[7 - j%8];
            if (j == dlast*8 + 7) ltime = int'($time);
        end
    endtask

    initial begin
        int v0, t_ref;
        #30;
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", data_out, 32'd0);
        #34;
        @(negedge clk_32f);
        reset = 1'b1;
        repeat (100) @(negedge clk_32f);
        check("idle_vcnt", vcnt, 32'd0);
        check("idle_data", data_out, 32'd0);
`ifdef PHY_RX_LOCK_STATUS_EN
        check("idle_lock", {30'd0, lock_out}, 32'd0);
`endif

        v0 = vcnt;
        play({8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11, 8'h22},
             {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h33, 8'h44}, 6, 0, 5, 6*8 + 24);
        check("noskew_vcnt", vcnt - v0, 32'd1);
        check("noskew_data", data_out, 32'h44223311);
        check("noskew_lat", vtime - ltime, 32'd30);
        t_ref = vtime - tstart;
`ifdef PHY_RX_LOCK_STATUS_EN
        check("noskew_lock", {30'd0, lock_out}, 32'd3);
        check("noskew_all", {31'd0, all_locked}, 32'd1);
`endif

        do_reset();
        check("reset_clear_data", data_out, 32'd0);
        v0 = vcnt;
        play({8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11, 8'h22},
             {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h33, 8'h44}, 6, 3, 5, 6*8 + 3 + 24);
        check("skew_vcnt", vcnt - v0, 32'd1);
        check("skew_data", data_out, 32'h44223311);
        check("skew_lat", vtime - ltime, 32'd30);
        check("skew_delay", (vtime - tstart) - t_ref, 32'd30);

        do_reset();
        v0 = vcnt;
        play({8'hBC, 8'hBC, 8'h5A, 8'hBC, 8'hBC, 8'hBC, 8'h11, 8'h22},
             {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h33, 8'h44}, 8, 0, 7, 8*8 + 24);
        check("acq_fail_vcnt", vcnt - v0, 32'd0);
`ifdef PHY_RX_LOCK_STATUS_EN
        check("acq_fail_lock", {30'd0, lock_out}, 32'd2);
        check("acq_fail_all", {31'd0, all_locked}, 32'd0);
`endif

        do_reset();
        v0 = vcnt;
        play({8'hBC, 8'hBC, 8'h5A, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11, 8'h22},
             {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h33, 8'h44}, 9, 0, 8, 9*8 + 24);
        check("reacq_vcnt", vcnt - v0, 32'd1);
        check("reacq_data", data_out, 32'h44223311);
        check("reacq_lat", vtime - ltime, 32'd30);

        do_reset();
        v0 = vcnt;
        play({8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11, 8'hBC, 8'hA1, 8'hA2},
             {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h33, 8'hBC, 8'hB1, 8'hB2}, 8, 0, 7, 8*8 + 24);
        check("comalign_vcnt", vcnt - v0, 32'd1);
        check("comalign_data", data_out, 32'hB2A2B1A1);

        v0 = vcnt;
        play({8'h11, 8'h22}, {8'h33, 8'h44}, 2, 0, -1, 8 + 4);
        check("pre_rst_data", data_out, 32'hB2A2B1A1);
        @(negedge clk_32f);
        reset = 1'b0;
        #1;
        check("midrst_data", data_out, 32'd0);
        check("midrst_valid", {31'd0, valid_out}, 32'd0);
`ifdef PHY_RX_LOCK_STATUS_EN
        check("midrst_lock", {30'd0, lock_out}, 32'd0);
`endif
        repeat (3) @(negedge clk_32f);
        reset   = 1'b1;
        data_in = '0;
        repeat (20) @(negedge clk_32f);
        check("midrst_vcnt", vcnt - v0, 32'd0);
        check("midrst_idle_data", data_out, 32'd0);
        v0 = vcnt;
        play({8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h55, 8'h66},
             {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h77, 8'h88}, 6, 0, 5, 6*8 + 24);
        check("after_rst_vcnt", vcnt - v0, 32'd1);
        check("after_rst_data", data_out, 32'h88667755);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
